// File: rtl/piso_shift_register_tx.sv
// rtl/piso_shift_register_tx.sv - LSB-first parallel-in/serial-out transmitter with load/ready handshake; optional PARITY_EN appends an even-parity bit
module piso_shift_register_tx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             busy,
    output logic             sout,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
`ifdef PARITY_EN
    logic               parity_q, parity_d;
`endif

    // State register; reset abandons any word in flight without a done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
`ifdef PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
`ifdef PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state: accept in IDLE, shift one bit per edge, done pulses on return to IDLE
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
`ifdef PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (load) begin
                    shreg_d  = din;
                    cnt_d    = '0;
                    state_d  = SHIFT;
`ifdef PARITY_EN
                    parity_d = ^din;
`endif
                end
            end
            SHIFT: begin
                shreg_d = shreg_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
`ifdef PARITY_EN
                    state_d = PARITY;
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode directly from state so reset takes effect without a clock
    always_comb begin
        ready = (state_q == IDLE);
        busy  = (state_q != IDLE);
        done  = done_q;
        sout  = 1'b0;
        if (state_q == SHIFT) begin
            sout = shreg_q[0];
        end
`ifdef PARITY_EN
        if (state_q == PARITY) begin
            sout = parity_q;
        end
`endif
    end

endmodule

// File: tb/tb_piso_shift_register_tx.sv
// tb/tb_piso_shift_register_tx.sv - randomized self-checking bench for piso_shift_register_tx against a line-level model
module tb_piso_shift_register_tx;

    localparam int W = 4;
`ifdef PARITY_EN
    localparam int L = W + 1;
`else
    localparam int L = W;
`endif

    logic         clk  = 1'b0;
    logic         rst  = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] din  = '0;
    logic         ready;
    logic         busy;
    logic         sout;
    logic         done;

    int n_vec = 0;
    int n_err = 0;

    piso_shift_register_tx #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .din   (din),
        .ready (ready),
        .busy  (busy),
        .sout  (sout),
        .done  (done)
    );

    always #5 clk = ~clk;

    // What the line carries for one word, in transmit order (index 0 first)
    function automatic logic [L-1:0] line_bits(input logic [W-1:0] w);
        logic [L-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) r[i] = w[i];
`ifdef PARITY_EN
        r[W] = ^w;
`endif
        return r;
    endfunction

    task automatic test_reset();
        rst  = 1'b1;
        load = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = W'($urandom);
            @(negedge clk);
            n_vec++;
            if ({ready, busy, sout, done} !== 4'b1000) begin
                n_err++;
                $display("FAIL reset_hold cycle %0d: ready/busy/sout/done=%b%b%b%b, expected 1000", i, ready, busy, sout, done);
            end
        end
        rst  = 1'b0;
        load = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({ready, busy, sout, done} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_release: ready/busy/sout/done=%b%b%b%b, expected 1000", ready, busy, sout, done);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] words [2];
        logic [L-1:0] exp;
        words[0] = 4'b1010;
        words[1] = 4'b1011;
        for (int j = 0; j < 2; j++) begin
            exp  = line_bits(words[j]);
            load = 1'b1;
            din  = words[j];
            @(posedge clk);
            #1;
            load = 1'b0;
            din  = W'($urandom);
            for (int k = 0; k < L; k++) begin
                @(negedge clk);
                n_vec++;
                if (sout !== exp[k] || busy !== 1'b1 || ready !== 1'b0 || done !== 1'b0) begin
                    n_err++;
                    $display("FAIL basic word %b bit %0d: sout=%b busy=%b ready=%b done=%b, expected sout=%b busy=1 ready=0 done=0",
                             words[j], k, sout, busy, ready, done, exp[k]);
                end
            end
            @(negedge clk);
            n_vec++;
            if ({ready, busy, sout, done} !== 4'b1001) begin
                n_err++;
                $display("FAIL basic_done word %b: ready/busy/sout/done=%b%b%b%b, expected 1001", words[j], ready, busy, sout, done);
            end
            @(negedge clk);
            n_vec++;
            if ({ready, busy, sout, done} !== 4'b1000) begin
                n_err++;
                $display("FAIL basic_after_done word %b: ready/busy/sout/done=%b%b%b%b, expected 1000", words[j], ready, busy, sout, done);
            end
        end
    endtask

    task automatic test_load_while_busy();
        logic [L-1:0] exp;
        int           ndone;
        exp  = line_bits(4'b0110);
        load = 1'b1;
        din  = 4'b0110;
        @(posedge clk);
        #1;
        load = 1'b0;
        for (int k = 0; k < L; k++) begin
            @(negedge clk);
            n_vec++;
            if (sout !== exp[k] || busy !== 1'b1 || ready !== 1'b0) begin
                n_err++;
                $display("FAIL busy_load bit %0d: sout=%b busy=%b ready=%b, expected sout=%b busy=1 ready=0", k, sout, busy, ready, exp[k]);
            end
            @(posedge clk);
            #1;
            load = (k + 1 < L);
            din  = 4'b1111;
        end
        load  = 1'b0;
        ndone = 0;
        for (int c = 0; c < L + 3; c++) begin
            if (c > 0) @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) ndone++;
            n_vec++;
            if (busy !== 1'b0 || sout !== 1'b0 || ready !== 1'b1) begin
                n_err++;
                $display("FAIL busy_load_ignored cycle %0d: busy=%b sout=%b ready=%b, expected busy=0 sout=0 ready=1", c, busy, sout, ready);
            end
        end
        n_vec++;
        if (ndone != 1) begin
            n_err++;
            $display("FAIL busy_load_done_count: got %0d done pulses, expected 1", ndone);
        end
    endtask

    task automatic test_back_to_back();
        logic q_sout [$];
        logic q_done [$];
        logic q_busy [$];
        logic [L-1:0] b1, b2;
        int ndone;
        b1 = line_bits(4'b0001);
        b2 = line_bits(4'b1000);
        for (int k = 0; k < L; k++) begin q_sout.push_back(b1[k]); q_done.push_back(1'b0); q_busy.push_back(1'b1); end
        q_sout.push_back(1'b0); q_done.push_back(1'b1); q_busy.push_back(1'b0);
        for (int k = 0; k < L; k++) begin q_sout.push_back(b2[k]); q_done.push_back(1'b0); q_busy.push_back(1'b1); end
        q_sout.push_back(1'b0); q_done.push_back(1'b1); q_busy.push_back(1'b0);
        q_sout.push_back(1'b0); q_done.push_back(1'b0); q_busy.push_back(1'b0);

        load = 1'b1;
        din  = 4'b0001;
        @(posedge clk);
        #1;
        din   = 4'b1000;
        ndone = 0;
        for (int i = 0; i < q_sout.size(); i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
            n_vec++;
            if (sout !== q_sout[i] || done !== q_done[i] || busy !== q_busy[i] || ready !== !q_busy[i]) begin
                n_err++;
                $display("FAIL back_to_back cycle %0d: sout=%b done=%b busy=%b ready=%b, expected sout=%b done=%b busy=%b ready=%b",
                         i + 1, sout, done, busy, ready, q_sout[i], q_done[i], q_busy[i], !q_busy[i]);
            end
            if (i == L) begin
                @(posedge clk);
                #1;
                load = 1'b0;
            end
        end
        n_vec++;
        if (ndone != 2) begin
            n_err++;
            $display("FAIL back_to_back_done_count: got %0d done pulses, expected 2", ndone);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [L-1:0] exp;
        int           ndone;
        load = 1'b1;
        din  = 4'b1111;
        @(posedge clk);
        #1;
        load = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_vec++;
            if (sout !== 1'b1 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL reset_mid_pre bit %0d: sout=%b busy=%b, expected sout=1 busy=1", k, sout, busy);
            end
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({ready, busy, sout, done} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_mid_async: ready/busy/sout/done=%b%b%b%b, expected 1000", ready, busy, sout, done);
        end
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        for (int c = 0; c < L + 2; c++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
            n_vec++;
            if ({ready, busy, sout} !== 3'b100) begin
                n_err++;
                $display("FAIL reset_mid_idle cycle %0d: ready/busy/sout=%b%b%b, expected 100", c, ready, busy, sout);
            end
        end
        n_vec++;
        if (ndone != 0) begin
            n_err++;
            $display("FAIL reset_mid_no_done: got %0d done pulses, expected 0", ndone);
        end
        exp  = line_bits(4'b0101);
        load = 1'b1;
        din  = 4'b0101;
        @(posedge clk);
        #1;
        load = 1'b0;
        for (int k = 0; k < L; k++) begin
            @(negedge clk);
            n_vec++;
            if (sout !== exp[k] || busy !== 1'b1) begin
                n_err++;
                $display("FAIL reset_mid_next bit %0d: sout=%b busy=%b, expected sout=%b busy=1", k, sout, busy, exp[k]);
            end
        end
        @(negedge clk);
        n_vec++;
        if ({ready, busy, sout, done} !== 4'b1001) begin
            n_err++;
            $display("FAIL reset_mid_next_done: ready/busy/sout/done=%b%b%b%b, expected 1001", ready, busy, sout, done);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [W-1:0] w;
        logic [L-1:0] exp;
        int           gap;
        for (int n = 0; n < 40; n++) begin
            w   = W'($urandom);
            gap = $urandom_range(0, 2);
            exp = line_bits(w);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                n_vec++;
                if ({ready, busy, sout, done} !== 4'b1000) begin
                    n_err++;
                    $display("FAIL random_idle word %0d gap %0d: ready/busy/sout/done=%b%b%b%b, expected 1000", n, g, ready, busy, sout, done);
                end
            end
            load = 1'b1;
            din  = w;
            @(posedge clk);
            #1;
            load = 1'b0;
            din  = W'($urandom);
            for (int k = 0; k < L; k++) begin
                @(negedge clk);
                n_vec++;
                if (sout !== exp[k] || busy !== 1'b1 || ready !== 1'b0 || done !== 1'b0) begin
                    n_err++;
                    $display("FAIL random word %0d (%b) bit %0d: sout=%b busy=%b ready=%b done=%b, expected sout=%b busy=1 ready=0 done=0",
                             n, w, k, sout, busy, ready, done, exp[k]);
                end
                load = (k < L - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                din  = W'($urandom);
            end
            @(negedge clk);
            n_vec++;
            if ({ready, busy, sout, done} !== 4'b1001) begin
                n_err++;
                $display("FAIL random_done word %0d: ready/busy/sout/done=%b%b%b%b, expected 1001", n, ready, busy, sout, done);
            end
        end
        @(negedge clk);
        n_vec++;
        if ({ready, busy, sout, done} !== 4'b1000) begin
            n_err++;
            $display("FAIL random_end: ready/busy/sout/done=%b%b%b%b, expected 1000", ready, busy, sout, done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_load_while_busy();
        test_back_to_back();
        test_reset_mid_word();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
